// File: rtl/secuenciador_transacciones_rtc.sv
// Sequencer that expands one host read/write request into a burst of single-register
// RTC bus transactions, driving the control-signal generator and the shared AD bus.
module secuenciador_transacciones_rtc #(
   parameter int unsigned N_REG      = 6,
   parameter logic [7:0]  ADDR_BASE  = 8'h21,
   parameter logic [7:0]  CMD_ADDR   = 8'hF0,
   parameter logic [7:0]  CMD_DATA   = 8'hF0,
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned TIMEOUT    = 63
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 rw_mode,
   input  logic [8*N_REG-1:0]   data_wr,
   output logic [8*N_REG-1:0]   data_rd,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic                 en_funcion,
   output logic                 in_escribir_leer,
   input  logic                 flag_done,
   input  logic                 out_flag_capturar_dato,
   input  logic                 out_direccion_dato,
   output logic [7:0]           ad_out,
   output logic                 ad_oe,
   input  logic [7:0]           ad_in
);

   localparam int DW = 8 * N_REG;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_SETUP, S_WAIT_DONE, S_GAP, S_FINISH, S_ABORT
   } state_t;

   state_t          state_q, state_d;
   logic            rw_q, rw_d;
   logic [DW-1:0]   data_wr_q, data_wr_d;
   logic [2:0]      idx_q, idx_d;
   logic            is_cmd_q, is_cmd_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            dir_q, dir_d;
   logic            en_q, en_d;
   logic            busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [DW-1:0]   shadow_q, shadow_d;
   logic [DW-1:0]   data_rd_q, data_rd_d;
   logic            load_txn;
   logic [2:0]      txn_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rw_q      <= 1'b0;
         data_wr_q <= '0;
         idx_q     <= '0;
         is_cmd_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         dir_q     <= 1'b0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         gap_q     <= '0;
         shadow_q  <= '0;
         data_rd_q <= '0;
      end else begin
         state_q   <= state_d;
         rw_q      <= rw_d;
         data_wr_q <= data_wr_d;
         idx_q     <= idx_d;
         is_cmd_q  <= is_cmd_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         dir_q     <= dir_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         shadow_q  <= shadow_d;
         data_rd_q <= data_rd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rw_d      = rw_q;
      data_wr_d = data_wr_q;
      idx_d     = idx_q;
      is_cmd_d  = is_cmd_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      shadow_d  = shadow_q;
      data_rd_d = data_rd_q;
      load_txn  = 1'b0;
      txn_idx   = idx_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               rw_d      = rw_mode;
               data_wr_d = data_wr;
               idx_d     = '0;
               state_d   = rw_mode ? S_SETUP : S_CMD;
            end
         end
         S_CMD: begin
            addr_d   = CMD_ADDR;
            wdata_d  = CMD_DATA;
            dir_d    = 1'b1;
            is_cmd_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_WAIT_DONE;
         end
         S_SETUP: begin
            load_txn = 1'b1;
            state_d  = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // flag_done has priority over the timeout terminal count
            if (flag_done) begin
               cnt_d   = '0;
               gap_d   = '0;
               state_d = S_GAP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               cnt_d   = '0;
               state_d = S_ABORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            // The last gap cycle also loads the next transaction, so en_funcion
            // stays low for exactly GAP_CYCLES cycles between transactions.
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
               gap_d = '0;
               if (is_cmd_q) begin
                  idx_d    = '0;
                  txn_idx  = '0;
                  load_txn = 1'b1;
                  state_d  = S_WAIT_DONE;
               end else if (idx_q == 3'(N_REG - 1)) begin
                  if (!rw_q) data_rd_d = shadow_q;
                  state_d = S_FINISH;
               end else begin
                  idx_d    = idx_q + 3'd1;
                  txn_idx  = idx_q + 3'd1;
                  load_txn = 1'b1;
                  state_d  = S_WAIT_DONE;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_FINISH: state_d = S_IDLE;
         S_ABORT:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      if (load_txn) begin
         addr_d   = ADDR_BASE + {5'd0, txn_idx};
         wdata_d  = data_wr_q[{txn_idx, 3'b000} +: 8];
         dir_d    = rw_q;
         is_cmd_d = 1'b0;
         cnt_d    = '0;
      end

      // Read data is valid whenever the generator is in the data phase but not asking us to drive
      if (state_q == S_WAIT_DONE && !is_cmd_q && !rw_q && out_direccion_dato && !ad_oe)
         shadow_d[{idx_q, 3'b000} +: 8] = ad_in;
   end

   assign en_d   = (state_d == S_WAIT_DONE);
   assign busy_d = (state_d == S_WAIT_DONE) || (state_d == S_GAP) ||
                   (state_d == S_FINISH) || (state_d == S_ABORT);

   assign en_funcion       = en_q;
   assign in_escribir_leer = dir_q;
   assign busy             = busy_q;
   assign done             = (state_q == S_FINISH);
   assign error            = (state_q == S_ABORT);
   assign data_rd          = data_rd_q;
   assign ad_oe            = en_q & out_flag_capturar_dato;
   assign ad_out           = out_direccion_dato ? wdata_q : addr_q;

endmodule
